// File: rtl/ps2_pkg.sv
// Shared types and default constants for the PS/2 receive path.
package ps2_pkg;

    localparam int unsigned DEF_FILTER_LEN   = 8;
    localparam int unsigned DEF_FIFO_DEPTH   = 4;
    localparam int unsigned DEF_TIMEOUT_CYC  = 50000;
    localparam bit          DEF_CHECK_PARITY = 1'b1;
    localparam int unsigned BYTE_W           = 8;

    typedef enum logic [2:0] {
        IDLE,
        DATA,
        PARITY,
        STOP,
        PUSH
    } ps2_state_t;

    // Odd parity over data plus parity bit: the total number of ones must be odd.
    function automatic logic parity_ok(input logic [BYTE_W-1:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/ps2_byte_fifo.sv
// First-word-fall-through byte FIFO with a registered head output.
module ps2_byte_fifo
    import ps2_pkg::*;
#(
    parameter int unsigned WIDTH = BYTE_W,
    parameter int unsigned DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           wr_en,
    input  logic [WIDTH-1:0]               wdata,
    input  logic                           rd_en,
    output logic [WIDTH-1:0]               rdata,
    output logic                           empty,
    output logic                           full,
    output logic [$clog2(DEPTH+1)-1:0]     count
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] rd_ptr_nxt_c;
    logic [CNT_W-1:0] count_nxt_c;
    logic             do_rd_c;
    logic             do_wr_c;

    // A write into a full FIFO is accepted only when a pop frees a slot this cycle.
    always_comb begin
        do_rd_c      = rd_en && !empty;
        do_wr_c      = wr_en && (!full || do_rd_c);
        rd_ptr_nxt_c = rd_ptr + PTR_W'(1);
        count_nxt_c  = count + CNT_W'(do_wr_c) - CNT_W'(do_rd_c);
    end

    always_ff @(posedge clk) begin
        if (do_wr_c) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            empty  <= 1'b1;
            full   <= 1'b0;
            rdata  <= '0;
        end else begin
            if (do_wr_c) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_rd_c) begin
                rd_ptr <= rd_ptr_nxt_c;
            end
            count <= count_nxt_c;
            empty <= (count_nxt_c == '0);
            full  <= (count_nxt_c == CNT_W'(DEPTH));
            // Head register tracks the next byte, bypassing memory when the FIFO runs dry.
            if (do_rd_c) begin
                if (count > CNT_W'(1)) begin
                    rdata <= mem[rd_ptr_nxt_c];
                end else if (do_wr_c) begin
                    rdata <= wdata;
                end
            end else if (empty && do_wr_c) begin
                rdata <= wdata;
            end
        end
    end

endmodule

// File: rtl/ps2_rx_buf.sv
// PS/2 device-to-host receiver: synchroniser, clock glitch filter, frame FSM and byte FIFO.
module ps2_rx_buf
    import ps2_pkg::*;
#(
    parameter int unsigned FILTER_LEN   = DEF_FILTER_LEN,
    parameter int unsigned FIFO_DEPTH   = DEF_FIFO_DEPTH,
    parameter int unsigned TIMEOUT_CYC  = DEF_TIMEOUT_CYC,
    parameter bit          CHECK_PARITY = DEF_CHECK_PARITY
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              ps2c,
    input  logic                              ps2d,
    input  logic                              rx_en,
    input  logic                              rd_en,
    output logic [BYTE_W-1:0]                 dout,
    output logic                              empty,
    output logic                              full,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   count,
    output logic                              parity_err,
    output logic                              frame_err,
    output logic                              timeout_err,
    output logic                              overflow
);

    localparam int unsigned TMO_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

    logic [1:0]            c_sync;
    logic [1:0]            d_sync;
    logic [FILTER_LEN-1:0] filt_sr;
    logic                  filt_clk;
    logic                  fall_edge;
    ps2_state_t            state;
    logic [BYTE_W-1:0]     shreg;
    logic [2:0]            bit_cnt;
    logic                  par_bit;
    logic [TMO_W-1:0]      tmo_cnt;
    logic                  push_c;
    logic                  d_s;

    assign d_s    = d_sync[1];
    assign push_c = (state == PUSH);

    // Synchronisers, glitch filter and falling-edge strobe on the filtered clock.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            c_sync    <= 2'b11;
            d_sync    <= 2'b11;
            filt_sr   <= '1;
            filt_clk  <= 1'b1;
            fall_edge <= 1'b0;
        end else begin
            c_sync    <= {c_sync[0], ps2c};
            d_sync    <= {d_sync[0], ps2d};
            filt_sr   <= {filt_sr[FILTER_LEN-2:0], c_sync[1]};
            fall_edge <= filt_clk && (filt_sr == '0);
            if (filt_sr == '1) begin
                filt_clk <= 1'b1;
            end else if (filt_sr == '0) begin
                filt_clk <= 1'b0;
            end
        end
    end

    // Frame FSM with inter-edge timeout; error outputs are single-cycle pulses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            shreg       <= '0;
            bit_cnt     <= '0;
            par_bit     <= 1'b0;
            tmo_cnt     <= '0;
            parity_err  <= 1'b0;
            frame_err   <= 1'b0;
            timeout_err <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            parity_err  <= 1'b0;
            frame_err   <= 1'b0;
            timeout_err <= 1'b0;
            overflow    <= 1'b0;
            case (state)
                IDLE: begin
                    tmo_cnt <= '0;
                    if (fall_edge && rx_en && !d_s) begin
                        bit_cnt <= '0;
                        state   <= DATA;
                    end
                end
                PUSH: begin
                    tmo_cnt  <= '0;
                    overflow <= full && !rd_en;
                    state    <= IDLE;
                end
                default: begin
                    if (fall_edge) begin
                        tmo_cnt <= '0;
                        case (state)
                            DATA: begin
                                shreg   <= {d_s, shreg[BYTE_W-1:1]};
                                bit_cnt <= bit_cnt + 3'd1;
                                if (bit_cnt == 3'd7) begin
                                    state <= PARITY;
                                end
                            end
                            PARITY: begin
                                par_bit <= d_s;
                                state   <= STOP;
                            end
                            STOP: begin
                                if (!d_s) begin
                                    frame_err <= 1'b1;
                                    state     <= IDLE;
                                end else if (CHECK_PARITY && !parity_ok(shreg, par_bit)) begin
                                    parity_err <= 1'b1;
                                    state      <= IDLE;
                                end else begin
                                    state <= PUSH;
                                end
                            end
                            default: state <= IDLE;
                        endcase
                    end else if (tmo_cnt == TMO_LAST) begin
                        timeout_err <= 1'b1;
                        tmo_cnt     <= '0;
                        state       <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                    end
                end
            endcase
        end
    end

    ps2_byte_fifo #(
        .WIDTH (BYTE_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .wr_en (push_c),
        .wdata (shreg),
        .rd_en (rd_en),
        .rdata (dout),
        .empty (empty),
        .full  (full),
        .count (count)
    );

endmodule
